instr_fetch: RTL and testbench

// - IF stage. Owns the PC, fetches instructions over a valid/ready instruction bus and drives the IF/ID pipe regs.
// - Output feeds the decode stage: if2id_valid/if2id_pc/if2id_instruction.
// - Takes branch/jump redirects from EX, and stalls from hazard control.
// - An in-order instruction buffer absorbs bus responses that return while the stage is stalled.

---
 rtl/instr_fetch.sv | 262 ++++++++++++++++++++++++++
 tb/tb_instr_fetch.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- instruction fetch (IF) stage
//
// Owns the program counter and issues word-aligned fetches on a valid/ready
// instruction bus.  In-order bus responses are tagged with their PC and loaded
// into the IF/ID pipe registers for decode.  Responses that return while
// decode is stalled go into a small in-order buffer.  Branch/jump redirects
// from EX flush the stage and discard any responses still in flight for the
// old path.
//
// Configuration macro:
//   CORE_IF_BUFFER_EN  defined     -> buffer depth 2, up to 2 outstanding fetches
//                      not defined -> buffer depth 1 (single skid entry)
//   Ports and reset behaviour are identical in both builds.
//
// Parameters:
//   PC_WIDTH    PC / bus address width
//   DATA_WIDTH  instruction width
//   RESET_PC    first fetch address after reset
//
// Ports:
//   clk                in   core clock
//   rst                in   synchronous reset, active high
//   ibus_req           out  fetch request valid (combinational, see below)
//   ibus_addr          out  fetch address, word aligned
//   ibus_ready         in   request accepted when ibus_req & ibus_ready
//   ibus_rvalid        in   response valid; responses return in order
//   ibus_rdata         in   response instruction
//   if_stall           in   hold the IF/ID registers (load-use hazard)
//   branch_take        in   redirect request from EX
//   branch_target      in   redirect address; bits [1:0] are ignored
//   if2id_valid        out  IF/ID instruction valid
//   if2id_pc           out  PC of if2id_instruction
//   if2id_instruction  out  fetched instruction (NOP after reset)
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned         PC_WIDTH   = 32,
   parameter int unsigned         DATA_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   // instruction bus
   output logic                  ibus_req,
   output logic [PC_WIDTH-1:0]   ibus_addr,
   input  logic                  ibus_ready,
   input  logic                  ibus_rvalid,
   input  logic [DATA_WIDTH-1:0] ibus_rdata,
   // pipeline control
   input  logic                  if_stall,
   input  logic                  branch_take,
   input  logic [PC_WIDTH-1:0]   branch_target,
   // IF/ID pipe registers
   output logic                  if2id_valid,
   output logic [PC_WIDTH-1:0]   if2id_pc,
   output logic [DATA_WIDTH-1:0] if2id_instruction
);

   // --------------------------------------------------------------------------
   // Configuration
   // --------------------------------------------------------------------------
`ifdef CORE_IF_BUFFER_EN
   localparam int unsigned BUF_DEPTH = 2;
`else
   localparam int unsigned BUF_DEPTH = 1;
`endif

   // Counters never exceed BUF_DEPTH (<= 2), so two bits are enough.
   localparam int unsigned CNT_W = 2;

   localparam logic [CNT_W:0]        DEPTH_CREDITS = (CNT_W+1)'(BUF_DEPTH);
   localparam logic [DATA_WIDTH-1:0] NOP_INSTR     = DATA_WIDTH'(32'h0000_0013);
   localparam logic [PC_WIDTH-1:0]   PC_STEP       = PC_WIDTH'(4);
   localparam logic [PC_WIDTH-1:0]   ALIGN_MASK    = ~PC_WIDTH'(3);

   // One fetched instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;   // next address to request
   logic [PC_WIDTH-1:0] resp_pc_q,  resp_pc_d;    // PC of next kept response
   logic [CNT_W-1:0]    out_cnt_q,  out_cnt_d;    // accepted, not yet returned
   logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;   // in-flight wrong-path responses
   logic [CNT_W-1:0]    buf_cnt_q,  buf_cnt_d;    // occupied buffer entries

   fetch_entry_t        buf_q [BUF_DEPTH];        // entry 0 is the head
   fetch_entry_t        buf_d [BUF_DEPTH];

   logic                if2id_valid_q, if2id_valid_d;
   fetch_entry_t        if2id_q,       if2id_d;

   // --------------------------------------------------------------------------
   // Per-cycle decisions
   // --------------------------------------------------------------------------
   logic                target_pc;
   logic [PC_WIDTH-1:0] target_aligned;
   fetch_entry_t        resp_entry;
   logic                resp_drop;    // response belongs to a flushed path
   logic                resp_keep;    // response is a valid, current-path instr
   logic                advance;      // IF/ID may load new contents
   logic                bypass;       // response goes straight into IF/ID
   logic                pop;          // buffer head goes into IF/ID
   logic                push;         // response goes into the buffer
   logic [CNT_W:0]      credit_used;  // outstanding requests + buffered instrs
   logic                issue;
   logic                accept;
   logic [CNT_W-1:0]    push_idx;

   assign target_pc      = 1'b0;
   assign target_aligned = branch_target & ALIGN_MASK;
   assign resp_entry     = '{pc: resp_pc_q, instr: ibus_rdata};

   // A redirect discards any same-cycle response and blocks every IF/ID load,
   // so both the keep and advance terms are gated by branch_take.
   assign resp_drop = ibus_rvalid & (drop_cnt_q != '0);
   assign resp_keep = ibus_rvalid & (drop_cnt_q == '0) & ~branch_take;
   assign advance   = ~if_stall & ~branch_take;

   // The buffer keeps program order: a response may only bypass it when empty.
   assign bypass = resp_keep & (buf_cnt_q == '0) & advance;
   assign pop    = advance & (buf_cnt_q != '0);
   assign push   = resp_keep & ~bypass;

   // Credit scheme: every outstanding request has a guaranteed buffer slot,
   // so a response can always be stored and the buffer never overflows.  When
   // all credits are in use, a response that leaves straight for IF/ID frees
   // one in the same cycle; this gives the combinational rvalid -> req path
   // needed for one instruction per cycle on a single-cycle bus.
   assign credit_used = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q};

   assign issue  = ~rst & ~branch_take &
                   ((credit_used < DEPTH_CREDITS) |
                    ((credit_used == DEPTH_CREDITS) & bypass));
   assign accept = issue & ibus_ready;

   // After a pop, everything shifts down one slot before the push lands.
   assign push_idx = buf_cnt_q - CNT_W'(pop);

   // --------------------------------------------------------------------------
   // PC and counter next-state
   // --------------------------------------------------------------------------
   // NOTE: combinational blocks use blocking '=' so later statements see the
   // earlier results; sequential blocks use '<=' so every flop samples
   // pre-edge values regardless of process order.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      out_cnt_d  = out_cnt_q + CNT_W'(accept) - CNT_W'(ibus_rvalid);
      drop_cnt_d = drop_cnt_q - CNT_W'(resp_drop);
      buf_cnt_d  = buf_cnt_q + CNT_W'(push) - CNT_W'(pop);

      if (accept) begin
         fetch_pc_d = fetch_pc_q + PC_STEP;   // wraps naturally at the top
      end
      if (resp_keep) begin
         resp_pc_d = resp_pc_q + PC_STEP;
      end

      if (branch_take) begin
         // Every request still outstanding after this cycle is wrong-path.
         // No request issues this cycle, so there is no accept to add, and
         // drop_cnt is bounded by out_cnt, which is bounded by BUF_DEPTH.
         fetch_pc_d = target_aligned;
         resp_pc_d  = target_aligned;
         drop_cnt_d = out_cnt_q - CNT_W'(ibus_rvalid);
         buf_cnt_d  = '0;
      end
   end

   // --------------------------------------------------------------------------
   // Instruction buffer next-state
   // --------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
         buf_d[i] = buf_q[i];
      end

      if (pop) begin
         for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
            buf_d[i] = buf_q[i+1];
         end
      end

      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
         if (push && (CNT_W'(i) == push_idx)) begin
            buf_d[i] = resp_entry;
         end
      end
   end

   // --------------------------------------------------------------------------
   // IF/ID next-state
   // --------------------------------------------------------------------------
   always_comb begin
      if2id_valid_d = if2id_valid_q;
      if2id_d       = if2id_q;

      if (branch_take) begin
         // Redirect wins over a stall; pc/instr keep their last values.
         if2id_valid_d = 1'b0;
      end else if (advance) begin
         if (pop) begin
            if2id_valid_d = 1'b1;
            if2id_d       = buf_q[0];
         end else if (bypass) begin
            if2id_valid_d = 1'b1;
            if2id_d       = resp_entry;
         end else begin
            if2id_valid_d = 1'b0;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         out_cnt_q     <= '0;
         drop_cnt_q    <= '0;
         buf_cnt_q     <= '0;
         if2id_valid_q <= 1'b0;
         if2id_q       <= '{pc: RESET_PC, instr: NOP_INSTR};
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         out_cnt_q     <= out_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         buf_cnt_q     <= buf_cnt_d;
         if2id_valid_q <= if2id_valid_d;
         if2id_q       <= if2id_d;
      end
   end

   // NOTE: buffer storage is left out of reset on purpose: buf_cnt_q says
   // which entries hold data, so their contents are never read before being
   // written, and a reset here would only add reset fan-out.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
         buf_q[i] <= buf_d[i];
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign ibus_req          = issue;
   assign ibus_addr         = fetch_pc_q;
   assign if2id_valid       = if2id_valid_q;
   assign if2id_pc          = if2id_q.pc;
   assign if2id_instruction = if2id_q.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch -- self-checking bench for instr_fetch
//
// The bus model echoes the request address as the instruction (rdata = addr)
// after a configurable number of cycles, in order.  A reference fetch pointer
// predicts every accepted address.  The predicted PC goes into a scoreboard
// queue, and each instruction that decode consumes (valid, not stalled, not
// redirected) is popped and compared.  A redirect flushes the queue and moves
// the reference pointer to the aligned target.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ready    = 1'b1;
   logic        ibus_rvalid   = 1'b0;
   logic [31:0] ibus_rdata    = '0;
   logic        if_stall      = 1'b0;
   logic        branch_take   = 1'b0;
   logic [31:0] branch_target = '0;
   logic        if2id_valid;
   logic [31:0] if2id_pc;
   logic [31:0] if2id_instruction;

   instr_fetch #(
      .PC_WIDTH   (32),
      .DATA_WIDTH (32),
      .RESET_PC   (RESET_PC)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .ibus_req          (ibus_req),
      .ibus_addr         (ibus_addr),
      .ibus_ready        (ibus_ready),
      .ibus_rvalid       (ibus_rvalid),
      .ibus_rdata        (ibus_rdata),
      .if_stall          (if_stall),
      .branch_take       (branch_take),
      .branch_target     (branch_target),
      .if2id_valid       (if2id_valid),
      .if2id_pc          (if2id_pc),
      .if2id_instruction (if2id_instruction)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } bus_txn_t;

   bus_txn_t    bus_q[$];   // accepted requests awaiting their response
   logic [31:0] exp_q[$];   // scoreboard: expected PCs in program order
   logic [31:0] model_pc;   // reference fetch pointer
   int unsigned cyc;
   int unsigned lat = 1;
   int          tests  = 0;
   int          failed = 0;
   int          consumed;

   logic        prev_hold;
   logic        prev_valid;
   logic [31:0] prev_pc;
   logic [31:0] prev_instr;

   // ---------------------------------------------------------------------------
   // Cycle helpers.  Inputs change 1 after posedge; outputs are sampled 2 after.
   // ---------------------------------------------------------------------------
   task automatic settle();
      if (bus_q.size() != 0 && bus_q[0].due <= cyc) begin
         ibus_rvalid = 1'b1;
         ibus_rdata  = bus_q[0].addr;
      end else begin
         ibus_rvalid = 1'b0;
         ibus_rdata  = '0;
      end
      #1;
      if (prev_hold) begin
         tests++;
         if ({if2id_valid, if2id_pc, if2id_instruction} !==
             {prev_valid, prev_pc, prev_instr}) begin
            failed++;
            $display("FAIL stall_hold cyc=%0d: got v=%0b pc=%h ins=%h, want v=%0b pc=%h ins=%h",
                     cyc, if2id_valid, if2id_pc, if2id_instruction,
                     prev_valid, prev_pc, prev_instr);
         end
      end
   endtask

   task automatic advance();
      logic [31:0] e;
      if (branch_take) begin
         tests++;
         if (ibus_req !== 1'b0) begin
            failed++;
            $display("FAIL no_req_on_redirect cyc=%0d: got req=%0b want 0", cyc, ibus_req);
         end
         exp_q.delete();
         model_pc = branch_target & ~32'h3;
      end else if (if2id_valid === 1'b1 && !if_stall) begin
         tests++;
         consumed++;
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL scoreboard cyc=%0d: got pc=%h, want nothing pending", cyc, if2id_pc);
         end else begin
            e = exp_q.pop_front();
            if (if2id_pc !== e || if2id_instruction !== e) begin
               failed++;
               $display("FAIL scoreboard cyc=%0d: got pc=%h ins=%h want pc=%h ins=%h",
                        cyc, if2id_pc, if2id_instruction, e, e);
            end
         end
      end
      if (ibus_req === 1'b1 && ibus_ready) begin
         tests++;
         if (ibus_addr !== model_pc) begin
            failed++;
            $display("FAIL fetch_addr cyc=%0d: got %h want %h", cyc, ibus_addr, model_pc);
         end
         exp_q.push_back(model_pc);
         bus_q.push_back('{addr: ibus_addr, due: cyc + lat});
         model_pc = model_pc + 32'd4;
      end
      if (ibus_rvalid) bus_q.delete(0);
      prev_hold  = if_stall && !branch_take;
      prev_valid = if2id_valid;
      prev_pc    = if2id_pc;
      prev_instr = if2id_instruction;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         advance();
      end
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      ibus_rvalid   = 1'b0;
      ibus_rdata    = '0;
      ibus_ready    = 1'b1;
      if_stall      = 1'b0;
      branch_take   = 1'b0;
      branch_target = '0;
      bus_q.delete();
      exp_q.delete();
      prev_hold     = 1'b0;
      model_pc      = RESET_PC;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (ibus_req !== 1'b0) begin
         failed++;
         $display("FAIL req_in_reset: got %0b want 0", ibus_req);
      end
      rst      = 1'b0;
      cyc      = 0;
      consumed = 0;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      tests++;
      if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b0, RESET_PC, NOP}) begin
         failed++;
         $display("FAIL reset_if2id: got v=%0b pc=%h ins=%h want v=0 pc=%h ins=%h",
                  if2id_valid, if2id_pc, if2id_instruction, RESET_PC, NOP);
      end
      settle();
      tests++;
      if (ibus_req !== 1'b1 || ibus_addr !== RESET_PC) begin
         failed++;
         $display("FAIL first_fetch: got req=%0b addr=%h want req=1 addr=%h",
                  ibus_req, ibus_addr, RESET_PC);
      end
      advance();
   endtask

   task automatic test_stream();
      do_reset();
      for (int c = 0; c < 12; c++) begin
         settle();
         if (c < 6) begin
            tests++;
            if (ibus_req !== 1'b1 || ibus_addr !== 32'(4 * c)) begin
               failed++;
               $display("FAIL stream_addr c=%0d: got req=%0b addr=%h want req=1 addr=%h",
                        c, ibus_req, ibus_addr, 32'(4 * c));
            end
         end
         tests++;
         if (c < 2) begin
            if (if2id_valid !== 1'b0) begin
               failed++;
               $display("FAIL stream_valid c=%0d: got %0b want 0", c, if2id_valid);
            end
         end else if (if2id_valid !== 1'b1 || if2id_pc !== 32'(4 * (c - 2))) begin
            failed++;
            $display("FAIL stream_pc c=%0d: got v=%0b pc=%h want v=1 pc=%h",
                     c, if2id_valid, if2id_pc, 32'(4 * (c - 2)));
         end
         advance();
      end
      tests++;
      if (consumed != 10) begin
         failed++;
         $display("FAIL stream_count: got %0d want 10", consumed);
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int c = 0; c < 14; c++) begin
         if_stall = (c >= 4 && c <= 6);
         settle();
         if (c >= 4 && c <= 6) begin
            tests++;
            if (if2id_valid !== 1'b1 || if2id_pc !== 32'h8) begin
               failed++;
               $display("FAIL stall_pc c=%0d: got v=%0b pc=%h want v=1 pc=00000008",
                        c, if2id_valid, if2id_pc);
            end
         end
         if (c == 6) begin
            tests++;
            if (ibus_req !== 1'b0) begin
               failed++;
               $display("FAIL stall_credit: got req=%0b want 0", ibus_req);
            end
         end
         if (c == 8) begin
            tests++;
            if (if2id_valid !== 1'b1 || if2id_pc !== 32'hC) begin
               failed++;
               $display("FAIL stall_resume: got v=%0b pc=%h want v=1 pc=0000000c",
                        if2id_valid, if2id_pc);
            end
         end
         advance();
      end
      if_stall = 1'b0;
      tests++;
      if (consumed < 8) begin
         failed++;
         $display("FAIL stall_count: got %0d want >= 8", consumed);
      end
   endtask

   task automatic test_ready_low();
      do_reset();
      for (int c = 0; c < 24; c++) begin
         ibus_ready = !(c >= 8 && c <= 12);
         settle();
         if (c >= 8 && c <= 12) begin
            tests++;
            if (ibus_req !== 1'b1 || ibus_addr !== 32'h20) begin
               failed++;
               $display("FAIL ready_hold c=%0d: got req=%0b addr=%h want req=1 addr=00000020",
                        c, ibus_req, ibus_addr);
            end
         end
         advance();
      end
      ibus_ready = 1'b1;
   endtask

   task automatic test_branch_outstanding();
      bit found = 1'b0;
      bit seen  = 1'b0;
      do_reset();
      lat = 2;
      run(6);
      for (int i = 0; i < 8 && !found; i++) begin
         if (bus_q.size() != 0 && bus_q[0].due > cyc) begin
            branch_take   = 1'b1;
            branch_target = 32'h100;
            found         = 1'b1;
         end
         settle();
         advance();
         branch_take = 1'b0;
      end
      tests++;
      if (!found) begin
         failed++;
         $display("FAIL branch_outstanding_setup: got no outstanding request, want one");
      end
      for (int i = 0; i < 20 && !seen; i++) begin
         settle();
         if (if2id_valid === 1'b1) begin
            seen = 1'b1;
            tests++;
            if (if2id_pc !== 32'h100) begin
               failed++;
               $display("FAIL branch_first_pc: got %h want 00000100", if2id_pc);
            end
         end
         advance();
      end
      tests++;
      if (!seen) begin
         failed++;
         $display("FAIL branch_timeout: got no valid if2id in 20 cycles, want pc 00000100");
      end
      run(6);
      tests++;
      if (dut.drop_cnt_q !== 2'd0) begin
         failed++;
         $display("FAIL drop_cnt_drain: got %0d want 0", dut.drop_cnt_q);
      end
      lat = 1;
   endtask

   task automatic test_redirect_stall();
      do_reset();
      run(6);
      if_stall      = 1'b1;
      branch_take   = 1'b1;
      branch_target = 32'h200;
      settle();
      advance();
      if_stall    = 1'b0;
      branch_take = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         settle();
         if (c <= 2) begin
            tests++;
            if (if2id_valid !== 1'b0) begin
               failed++;
               $display("FAIL redirect_bubble c=%0d: got v=%0b want 0", c, if2id_valid);
            end
         end
         if (c == 3) begin
            tests++;
            if (if2id_valid !== 1'b1 || if2id_pc !== 32'h200) begin
               failed++;
               $display("FAIL redirect_target: got v=%0b pc=%h want v=1 pc=00000200",
                        if2id_valid, if2id_pc);
            end
         end
         advance();
      end
   endtask

   task automatic test_wrap_align();
      do_reset();
      run(3);
      branch_take   = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      settle();
      advance();
      branch_take = 1'b0;
      settle();
      tests++;
      if (ibus_req !== 1'b1 || ibus_addr !== 32'hFFFF_FFFC) begin
         failed++;
         $display("FAIL wrap_top: got req=%0b addr=%h want req=1 addr=fffffffc", ibus_req, ibus_addr);
      end
      advance();
      settle();
      tests++;
      if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin
         failed++;
         $display("FAIL wrap_zero: got req=%0b addr=%h want req=1 addr=00000000", ibus_req, ibus_addr);
      end
      advance();
      run(5);
      branch_take   = 1'b1;
      branch_target = 32'h103;
      settle();
      advance();
      branch_take = 1'b0;
      settle();
      tests++;
      if (ibus_req !== 1'b1 || ibus_addr !== 32'h100) begin
         failed++;
         $display("FAIL target_align: got req=%0b addr=%h want req=1 addr=00000100", ibus_req, ibus_addr);
      end
      advance();
      run(6);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_ready_low();
      test_branch_outstanding();
      test_redirect_stall();
      test_wrap_align();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within 100000 time units");
      $fatal(1, "timeout");
   end

endmodule
